fir_axis_out: RTL and testbench
===============================

# fir_axis_out

Output stage of the FIR accelerator. It sits directly downstream of the FIR compute core, which presents one filtered sample Y per cycle on a valid/ready pair. The block buffers Y samples in a small FIFO and drives the AXI-Stream master port (sm_*). It counts samples against the programmed data length, asserts `sm_tlast` on the final beat, and pulses `done` so the control register can set ap_done/ap_idle.

## Interface
Parameters:
- `pDATA_WIDTH`, 32, width of Y samples and `sm_tdata`.
- `FIFO_DEPTH`, 4, number of Y entries buffered; must be ≥ 2 and a power of 2.

Ports:
- `axis_clk`  in  1  clock; all logic is on the rising edge.
- `axis_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse from the control register on ap_start; honoured only in IDLE.
- `data_length`  in  32  number of Y samples in the run; sampled on an accepted `start`.
- `y_valid`  in  1  core presents a Y sample.
- `y_data`  in  pDATA_WIDTH  Y sample.
- `y_ready`  out  1  block accepts Y this cycle.
- `sm_tready`  in  1  downstream sink ready.
- `sm_tvalid`  out  1  FIFO head valid.
- `sm_tdata`  out  pDATA_WIDTH  FIFO head data.
- `sm_tlast`  out  1  head is the final sample of the run.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `busy`  out  1  high in RUN and DONE.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE → RUN on `start`: latch `data_length` into `len`; clear `in_cnt`, `out_cnt` and the FIFO.
  - IDLE → DONE on `start` when `data_length` == 0. No beats are emitted.
  - RUN → DONE on the cycle the output handshake (`sm_tvalid & sm_tready`) occurs with `out_cnt == len-1`.
  - DONE → IDLE unconditionally after 1 cycle. `done` = 1 only in DONE.
- `start` in RUN or DONE is ignored; the latched `len` is unchanged.
- Input side:
  - `y_ready` = (state == RUN) & !fifo_full & (`in_cnt` < `len`).
  - A push occurs on `y_valid & y_ready`; `in_cnt` increments on each push.
  - In IDLE/DONE, `y_ready` = 0 and `y_valid` is ignored; nothing is stored.
- Output side:
  - `sm_tvalid` = !fifo_empty.
  - `sm_tdata` = head entry, driven straight from the FIFO register (no combinational path from `y_data`).
  - A pop occurs on `sm_tvalid & sm_tready`; `out_cnt` increments on each pop.
  - `sm_tlast` = `sm_tvalid` & (`out_cnt` == `len`-1).
- FIFO:
  - Circular buffer with read/write pointers of width log2(FIFO_DEPTH)+1; the MSB distinguishes full from empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop in the same cycle: occupancy is unchanged, both pointers advance.
  - When full, `y_ready` = 0 even if a pop occurs in the same cycle (no full-bypass).
- Counters are 32 bits; `len` is treated as unsigned and there is no wrap within a run.
- Reset while in RUN: the FIFO is flushed, partial data is discarded, and the state returns to IDLE immediately.

## Timing
- Reset values: `y_ready`=0, `sm_tvalid`=0, `sm_tdata`=0, `sm_tlast`=0, `done`=0, `busy`=0; state IDLE; pointers, counters and `len` = 0.
- `start` accepted in cycle N: RUN from cycle N+1, so `y_ready` can be 1 from N+1.
- Latency: Y pushed into an empty FIFO in cycle N gives `sm_tvalid`=1 with that data in cycle N+1.
- Throughput: 1 sample/cycle sustained while `sm_tready`=1.
- With `sm_tready` held 0, the FIFO fills after FIFO_DEPTH pushes, then `y_ready` = 0.
- AXI-Stream rule: once `sm_tvalid`=1, `sm_tdata`/`sm_tlast` stay stable and `sm_tvalid` stays high until the handshake.
- Final beat accepted in cycle M: `done`=1 in cycle M+1, and the state is IDLE in cycle M+2.
- `busy` tracks the state registers (1 in RUN and DONE).

## Test plan
- Basic run: `data_length`=5, `start`; core sends Y = 1..5 back-to-back with `sm_tready`=1 → `sm_tdata` 1..5 on consecutive cycles, each one cycle after its input; `sm_tlast`=1 only on 5; `done` pulses 1 cycle after the beat carrying 5.
- Backpressure: `data_length`=8, `sm_tready`=0 for 10 cycles, `y_valid` held 1 → exactly 4 pushes, then `y_ready`=0 and `sm_tvalid` held with data 1 stable. Release `sm_tready` → output 1..8 in order with no loss or duplication.
- Concurrent push/pop while full: FIFO full, `sm_tready`=1, `y_valid`=1 → `y_ready`=0 that cycle and 1 the next cycle; ordering preserved across pointer wrap (16-sample run with random `sm_tready`).
- Zero length: `data_length`=0, `start` → `done` pulses in the next cycle; `sm_tvalid` never asserts; `y_ready` stays 0.
- Ignored inputs: `y_valid`=1 in IDLE → no output. A second `start` with `data_length`=3 during a run of 6 → exactly 6 beats, `sm_tlast` on the 6th.
- Mid-run reset: assert `axis_rst_n`=0 after 3 of 6 beats → all outputs 0 immediately. A fresh run with `data_length`=2 then outputs exactly 2 new samples.

Source files
------------

// File: rtl/fir_axis_out.sv
// FIR output stage: buffers Y samples from the compute core in a small FIFO,
// drives the AXI-Stream master, and flags the final beat and run completion.
module fir_axis_out #(
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [31:0]            data_length,
  input  logic                   y_valid,
  input  logic [pDATA_WIDTH-1:0] y_data,
  output logic                   y_ready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic                   done,
  output logic                   busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            len_q, len_d;
  logic [31:0]            in_cnt_q, in_cnt_d;
  logic [31:0]            out_cnt_q, out_cnt_d;
  logic [AW:0]            wptr_q, wptr_d;
  logic [AW:0]            rptr_q, rptr_d;
  logic [pDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, last_beat;

  // Extra pointer MSB separates the full case from the empty case.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign y_ready   = (state_q == S_RUN) && !full && (in_cnt_q < len_q);
  assign push      = y_valid && y_ready;
  assign sm_tvalid = !empty;
  assign sm_tdata  = mem_q[rptr_q[AW-1:0]];
  assign pop       = sm_tvalid && sm_tready;
  assign last_beat = (out_cnt_q == len_q - 32'd1);
  assign sm_tlast  = sm_tvalid && last_beat;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = data_length;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          wptr_d    = '0;
          rptr_d    = '0;
          state_d   = (data_length == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push) begin
          wptr_d   = wptr_q + {{AW{1'b0}}, 1'b1};
          in_cnt_d = in_cnt_q + 32'd1;
        end
        if (pop) begin
          rptr_d    = rptr_q + {{AW{1'b0}}, 1'b1};
          out_cnt_d = out_cnt_q + 32'd1;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // Storage is cleared on reset so the head reads 0 while the FIFO is flushed.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= y_data;
    end
  end

endmodule

// File: tb/tb_fir_axis_out.sv
// Directed bench for fir_axis_out: streaming, backpressure, wrap, zero length,
// ignored inputs and mid-run reset, all with hand-derived expectations.
module tb_fir_axis_out;
  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        start;
  logic [31:0] data_length;
  logic        y_valid;
  logic [31:0] y_data;
  logic        y_ready;
  logic        sm_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        done;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int nin, nout;

  fir_axis_out #(.pDATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start),
    .data_length(data_length), .y_valid(y_valid), .y_data(y_data),
    .y_ready(y_ready), .sm_tready(sm_tready), .sm_tvalid(sm_tvalid),
    .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .done(done), .busy(busy)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic cyc();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic begin_run(input int len);
    data_length = len;
    start = 1'b1;
    cyc();
    start = 1'b0;
    nin = 0;
    nout = 0;
  endtask

  // Feeds base+k for k=0..n-1 and checks the output stream in order.
  task automatic drive(input int n, input int base, input bit rnd,
                       input int restart_at, input int abort_at);
    bit fin, hs_in, hs_out, hold;
    logic [31:0] hdat;
    fin = 0; hold = 0; hdat = '0;
    for (int c = 0; c < 400 && !fin; c++) begin
      start       = (c == restart_at);
      data_length = (c == restart_at) ? 32'd3 : 32'd0;
      y_valid     = (nin < n);
      y_data      = base + nin;
      sm_tready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) begin
        n_chk++;
        if (sm_tvalid !== 1'b1 || sm_tdata !== hdat) begin
          n_fail++;
          $display("FAIL stable_hold: tvalid=%0b tdata=%0d want tvalid=1 tdata=%0d", sm_tvalid, sm_tdata, hdat);
        end
      end
      hs_in  = y_valid && y_ready;
      hs_out = sm_tvalid && sm_tready;
      if (hs_out) begin
        n_chk++;
        if (sm_tdata !== 32'(base + nout) || sm_tlast !== (nout == n - 1)) begin
          n_fail++;
          $display("FAIL beat%0d: tdata=%0d tlast=%0b want tdata=%0d tlast=%0b",
                   nout, sm_tdata, sm_tlast, base + nout, (nout == n - 1));
        end
      end
      hold = sm_tvalid && !sm_tready;
      hdat = sm_tdata;
      cyc();
      if (hs_in) nin++;
      if (hs_out) nout++;
      if (nout == abort_at) fin = 1;
      else if (nout == n) begin
        fin = 1;
        n_chk++;
        if (done !== 1'b1 || sm_tvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL done_pulse: done=%0b tvalid=%0b want done=1 tvalid=0", done, sm_tvalid);
        end
      end
    end
    start = 1'b0;
    y_valid = 1'b0;
    sm_tready = 1'b1;
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: got %0d beats want %0d", nout, n);
    end else if (nout == n) begin
      cyc();
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_idle: done=%0b busy=%0b want 0 0", done, busy);
      end
    end
  endtask

  task automatic check_all_zero(input string nm);
    n_chk++;
    if ({y_ready, sm_tvalid, sm_tlast, done, busy} !== 5'b0 || sm_tdata !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: ready=%0b tvalid=%0b tdata=%0d tlast=%0b done=%0b busy=%0b want all 0",
               nm, y_ready, sm_tvalid, sm_tdata, sm_tlast, done, busy);
    end
  endtask

  task automatic test_reset();
    axis_rst_n = 1'b0;
    #3;
    check_all_zero("reset");
    #4;
    axis_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    sm_tready = 1'b1;
    begin_run(5);
    n_chk++;
    if (y_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_run_entry: ready=%0b busy=%0b want 1 1", y_ready, busy);
    end
    for (int i = 1; i <= 5; i++) begin
      y_valid = 1'b1;
      y_data  = i;
      cyc();
      n_chk++;
      if (sm_tvalid !== 1'b1 || sm_tdata !== 32'(i) || sm_tlast !== (i == 5)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: tvalid=%0b tdata=%0d tlast=%0b want 1 %0d %0b",
                 i, sm_tvalid, sm_tdata, sm_tlast, i, (i == 5));
      end
    end
    y_valid = 1'b0;
    n_chk++;
    if (y_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_len_reached: ready=%0b want 0", y_ready);
    end
    cyc();
    n_chk++;
    if (done !== 1'b1 || sm_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: done=%0b tvalid=%0b want 1 0", done, sm_tvalid);
    end
    cyc();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: done=%0b busy=%0b want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    begin_run(8);
    sm_tready = 1'b0;
    y_valid   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      y_data = nin + 1;
      if (y_ready) nin++;
      cyc();
      if (nin > 0) begin
        n_chk++;
        if (sm_tvalid !== 1'b1 || sm_tdata !== 32'd1) begin
          n_fail++; $display("FAIL bp_head_c%0d: tvalid=%0b tdata=%0d want 1 1", c, sm_tvalid, sm_tdata);
        end
      end
    end
    n_chk++;
    if (nin !== 4 || y_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_fill: pushes=%0d ready=%0b want 4 0", nin, y_ready);
    end
    // Full with a pop this cycle: still no push until the next cycle.
    sm_tready = 1'b1;
    y_data = nin + 1;
    cyc();
    nout = 1;
    n_chk++;
    if (y_ready !== 1'b1 || sm_tdata !== 32'd2) begin
      n_fail++; $display("FAIL full_no_bypass: ready=%0b tdata=%0d want 1 2", y_ready, sm_tdata);
    end
    drive(8, 1, 1'b0, -1, -1);
  endtask

  task automatic test_wrap_random();
    begin_run(16);
    drive(16, 1, 1'b1, -1, -1);
  endtask

  task automatic test_zero_length();
    begin_run(0);
    n_chk++;
    if (done !== 1'b1 || sm_tvalid !== 1'b0 || y_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_done: done=%0b tvalid=%0b ready=%0b want 1 0 0", done, sm_tvalid, y_ready);
    end
    y_valid = 1'b1;
    cyc();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || sm_tvalid !== 1'b0 || y_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_idle: done=%0b busy=%0b tvalid=%0b ready=%0b want 0", done, busy, sm_tvalid, y_ready);
    end
    y_valid = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    y_valid = 1'b1;
    y_data  = 32'hdead;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_chk++;
      if (y_ready !== 1'b0 || sm_tvalid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_ignore_c%0d: ready=%0b tvalid=%0b busy=%0b want 0", c, y_ready, sm_tvalid, busy);
      end
    end
    y_valid = 1'b0;
    begin_run(6);
    drive(6, 10, 1'b0, 2, -1);
  endtask

  task automatic test_midrun_reset();
    begin_run(6);
    drive(6, 1, 1'b0, -1, 3);
    axis_rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    #2;
    axis_rst_n = 1'b1;
    cyc();
    begin_run(2);
    drive(2, 100, 1'b0, -1, -1);
  endtask

  initial begin
    start = 1'b0; data_length = '0; y_valid = 1'b0; y_data = '0; sm_tready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_random();
    test_zero_length();
    test_ignored_inputs();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
